mc_main_ctrl: RTL and testbench
===============================

# mc_main_ctrl

Multicycle main control unit for the MIPS datapath: a Moore state machine that sequences fetch, decode, execute, memory and write-back, and drives the datapath enables. It produces the 3-bit ALU operation class consumed by `ALU_Ctrl` on `ALUOp_i`. Together with `funct`, that class selects the ALU function. Memory accesses use a ready handshake, so the unit stalls on slow memory.

## Interface
- No parameters.
- `clk_i`  in  1  system clock, rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `instr_op_i`  in  6  opcode field of the instruction register; stable from `DECODE` until the next `FETCH`.
- `mem_ready_i`  in  1  memory completes the current read/write this cycle.
- `ALUOp_o`  out  3  ALU class: 100 add, 101 sub, 010 R-type (funct decides).
- `ALUSrcA_o`  out  1  0 = PC, 1 = register A.
- `ALUSrcB_o`  out  2  00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- `IorD_o`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `MemRead_o`, `MemWrite_o`  out  1 each  memory strobes.
- `IRWrite_o`  out  1  instruction register load.
- `PCWrite_o`, `PCWriteCond_o`  out  1 each  unconditional / zero-conditioned PC load.
- `PCSource_o`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `RegWrite_o`, `RegDst_o`, `MemtoReg_o`  out  1 each  register-file write, rd select, memory-data select.
- `state_o`  out  4  current state encoding (debug).
- `instr_done_o`  out  1  one-cycle pulse in the final cycle of each retired instruction.
- `illegal_o`  out  1  one-cycle pulse on an unsupported opcode.

## Operation
- State encodings: `INIT` 0, `FETCH` 1, `DECODE` 2, `MEMADR` 3, `MEMRD` 4, `MEMWB` 5, `MEMWR` 6, `REXEC` 7, `RWB` 8, `BRANCH` 9, `IEXEC` 10, `IWB` 11, `JUMP` 12. Codes 13–15 return to `INIT`.
- Outputs not listed for a state are 0, and `ALUOp_o` defaults to 100.
- `INIT`: all enables 0. Next state is `FETCH`.
- `FETCH`: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `PCSource`=00.
  - `IRWrite` and `PCWrite` equal `mem_ready_i`; this is the only Mealy gating in the unit.
  - Stays in `FETCH` while `mem_ready_i`=0, else goes to `DECODE`.
- `DECODE`: `ALUSrcA`=0, `ALUSrcB`=11 (precomputes the branch target). Next state by opcode:
  - 000000 → `REXEC`
  - 100011 or 101011 → `MEMADR`
  - 000100 → `BRANCH`
  - 001000 → `IEXEC`
  - 000010 → `JUMP`
  - any other opcode → `FETCH` with `illegal_o`=1.
- `MEMADR`: `ALUSrcA`=1, `ALUSrcB`=10. Opcode 100011 → `MEMRD`, otherwise `MEMWR`.
- `MEMRD`: `MemRead`=1, `IorD`=1. Waits for `mem_ready_i`, then → `MEMWB`.
- `MEMWB`: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0, `instr_done`=1. Next state `FETCH`.
- `MEMWR`: `MemWrite`=1, `IorD`=1. On `mem_ready_i` → `FETCH` with `instr_done`=1 in that cycle.
- `REXEC`: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=010. Next state `RWB`.
- `RWB`: `RegWrite`=1, `RegDst`=1, `instr_done`=1. Next state `FETCH`.
- `BRANCH`: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=101, `PCWriteCond`=1, `PCSource`=01, `instr_done`=1. Next state `FETCH`.
- `IEXEC`: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=100. Next state `IWB`.
- `IWB`: `RegWrite`=1, `RegDst`=0, `instr_done`=1. Next state `FETCH`.
- `JUMP`: `PCWrite`=1, `PCSource`=10, `instr_done`=1. Next state `FETCH`.

## Timing
- Reset asserted: state is `INIT` immediately (asynchronous). `state_o`=0, `ALUOp_o`=100, and every other output is 0.
- First `FETCH` occurs in the first cycle after reset deasserts.
- Reset during any state, including a memory wait, returns to `INIT` at once. All strobes drop in the same cycle.
- Cycles per instruction with zero-wait memory:
  - R-type 4, lw 5, sw 4, beq 3, addi 4, j 3, illegal 2.
- Each cycle of `mem_ready_i`=0 in `FETCH`, `MEMRD` or `MEMWR` adds one cycle. Strobes and address selects stay constant while waiting.
- `instr_done_o` pulses exactly once per retired instruction and never during stalls.

## Test plan
- Reset: hold `rst_i`=0 → `state_o`=0, all strobes 0, `ALUOp_o`=100. Release → `FETCH` next cycle with `MemRead_o`=1.
- R-type, zero-wait (`instr_op_i`=000000, `mem_ready_i`=1):
  - states 1,2,7,8.
  - `ALUOp_o`=010 in `REXEC`.
  - `RegWrite_o`=`RegDst_o`=1 and `instr_done_o`=1 in cycle 4.
- lw with a 2-cycle stall in `MEMRD`:
  - states 1,2,3,4,4,4,5.
  - `IorD_o`=1 held for all three `MEMRD` cycles.
  - `MemtoReg_o`=1 in `MEMWB`.
- beq then j, back to back:
  - `BRANCH`: `ALUOp_o`=101, `PCWriteCond_o`=1, `PCSource_o`=01.
  - `JUMP`: `PCWrite_o`=1, `PCSource_o`=10.
  - 3 cycles each.
- Fetch stall (`mem_ready_i`=0 for 3 cycles) → `IRWrite_o`/`PCWrite_o` stay 0 until the ready cycle, then pulse once.
- Illegal opcode 111111 → `illegal_o`=1 in `DECODE`, no `instr_done_o`, back in `FETCH` next cycle. Async reset mid-`MEMWR` → `MemWrite_o` drops immediately.

Source files
------------

// File: rtl/mc_main_ctrl_if.sv
// Datapath-facing bundle of the multicycle main control unit.
// The controller uses the master modport and the datapath/memory side uses the slave modport.
interface mc_main_ctrl_if;
  logic [5:0] instr_op_i;
  logic       mem_ready_i;
  logic [2:0] ALUOp_o;
  logic       ALUSrcA_o;
  logic [1:0] ALUSrcB_o;
  logic       IorD_o;
  logic       MemRead_o;
  logic       MemWrite_o;
  logic       IRWrite_o;
  logic       PCWrite_o;
  logic       PCWriteCond_o;
  logic [1:0] PCSource_o;
  logic       RegWrite_o;
  logic       RegDst_o;
  logic       MemtoReg_o;
  logic [3:0] state_o;
  logic       instr_done_o;
  logic       illegal_o;

  modport master (
    input  instr_op_i, mem_ready_i,
    output ALUOp_o, ALUSrcA_o, ALUSrcB_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
           PCWrite_o, PCWriteCond_o, PCSource_o, RegWrite_o, RegDst_o, MemtoReg_o,
           state_o, instr_done_o, illegal_o
  );

  modport slave (
    output instr_op_i, mem_ready_i,
    input  ALUOp_o, ALUSrcA_o, ALUSrcB_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
           PCWrite_o, PCWriteCond_o, PCSource_o, RegWrite_o, RegDst_o, MemtoReg_o,
           state_o, instr_done_o, illegal_o
  );
endinterface

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch/decode/execute/memory/write-back,
// with memory-ready stalls. Control word is registered from the next state.
module mc_main_ctrl (
  input  logic          clk_i,
  input  logic          rst_i,
  mc_main_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    StInit   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StRExec  = 4'd7,
    StRWb    = 4'd8,
    StBranch = 4'd9,
    StIExec  = 4'd10,
    StIWb    = 4'd11,
    StJump   = 4'd12
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [2:0] AluAdd   = 3'b100;
  localparam logic [2:0] AluSub   = 3'b101;
  localparam logic [2:0] AluRType = 3'b010;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       fetch;       // IRWrite/PCWrite gated by mem_ready
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       done;
  } ctrl_t;

  localparam ctrl_t CtrlIdle = '{alu_op: AluAdd, default: '0};

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   op_legal;

  function automatic ctrl_t moore_ctrl(state_e s);
    ctrl_t c;
    c = CtrlIdle;
    case (s)
      StFetch: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.fetch     = 1'b1;
      end
      StDecode: c.alu_src_b = 2'b11;
      StMemAdr: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      StMemRd: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      StMemWb: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.done       = 1'b1;
      end
      StMemWr: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      StRExec: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = AluRType;
      end
      StRWb: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.done      = 1'b1;
      end
      StBranch: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = AluSub;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.done          = 1'b1;
      end
      StIExec: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      StIWb: begin
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      StJump: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
        c.done      = 1'b1;
      end
      default: c = CtrlIdle;
    endcase
    return c;
  endfunction

  always_comb begin
    op_legal = 1'b0;
    case (bus.instr_op_i)
      OpRType, OpLw, OpSw, OpBeq, OpAddi, OpJ: op_legal = 1'b1;
      default:                                 op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StInit:   state_d = StFetch;
      StFetch:  state_d = bus.mem_ready_i ? StDecode : StFetch;
      StDecode: begin
        case (bus.instr_op_i)
          OpRType:    state_d = StRExec;
          OpLw, OpSw: state_d = StMemAdr;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StIExec;
          OpJ:        state_d = StJump;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (bus.instr_op_i == OpLw) ? StMemRd : StMemWr;
      StMemRd:  state_d = bus.mem_ready_i ? StMemWb : StMemRd;
      StMemWb:  state_d = StFetch;
      StMemWr:  state_d = bus.mem_ready_i ? StFetch : StMemWr;
      StRExec:  state_d = StRWb;
      StRWb:    state_d = StFetch;
      StBranch: state_d = StFetch;
      StIExec:  state_d = StIWb;
      StIWb:    state_d = StFetch;
      StJump:   state_d = StFetch;
      default:  state_d = StInit;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StInit;
      ctrl_q  <= CtrlIdle;
    end else begin
      state_q <= state_d;
      ctrl_q  <= moore_ctrl(state_d);
    end
  end

  assign bus.ALUOp_o       = ctrl_q.alu_op;
  assign bus.ALUSrcA_o     = ctrl_q.alu_src_a;
  assign bus.ALUSrcB_o     = ctrl_q.alu_src_b;
  assign bus.IorD_o        = ctrl_q.iord;
  assign bus.MemRead_o     = ctrl_q.mem_read;
  assign bus.MemWrite_o    = ctrl_q.mem_write;
  assign bus.IRWrite_o     = ctrl_q.fetch & bus.mem_ready_i;
  assign bus.PCWrite_o     = ctrl_q.pc_write | (ctrl_q.fetch & bus.mem_ready_i);
  assign bus.PCWriteCond_o = ctrl_q.pc_write_cond;
  assign bus.PCSource_o    = ctrl_q.pc_source;
  assign bus.RegWrite_o    = ctrl_q.reg_write;
  assign bus.RegDst_o      = ctrl_q.reg_dst;
  assign bus.MemtoReg_o    = ctrl_q.mem_to_reg;
  assign bus.state_o       = state_q;
  // A store retires in the cycle its write completes.
  assign bus.instr_done_o  = ctrl_q.done | (ctrl_q.mem_write & bus.mem_ready_i);
  assign bus.illegal_o     = (state_q == StDecode) & ~op_legal;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Self-checking bench for mc_main_ctrl: each instruction is expanded into its expected
// per-cycle control trace (with random stalls) and compared against the DUT cycle by cycle.
module tb_mc_main_ctrl;

  localparam int KR = 0, KLW = 1, KSW = 2, KBEQ = 3, KADDI = 4, KJ = 5, KILL = 6;

  typedef struct packed {
    logic [2:0] alu;
    logic       src_a;
    logic [1:0] src_b;
    logic       iord, mr, mw, irw, pcw, pcwc;
    logic [1:0] pcsrc;
    logic       rw, rdst, m2r, done, ill;
  } ctl_t;

  typedef struct {
    logic [3:0] st;
    logic [5:0] op;
    logic       ready;
    ctl_t       ctl;
    int         iid;
  } cyc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc_main_ctrl_if bus ();

  mc_main_ctrl dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc_no = 0;
  int   instr_no = 0;
  int   done_seen = 0;
  int   retired_exp = 0;
  cyc_t q[$];
  ctl_t idle_ctl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d instr=%0d got=%h expected=%h", tag, cyc_no, instr_no, obs,
               exp);
    end
  endtask

  function automatic ctl_t obs_ctl();
    ctl_t o;
    o.alu   = bus.ALUOp_o;
    o.src_a = bus.ALUSrcA_o;
    o.src_b = bus.ALUSrcB_o;
    o.iord  = bus.IorD_o;
    o.mr    = bus.MemRead_o;
    o.mw    = bus.MemWrite_o;
    o.irw   = bus.IRWrite_o;
    o.pcw   = bus.PCWrite_o;
    o.pcwc  = bus.PCWriteCond_o;
    o.pcsrc = bus.PCSource_o;
    o.rw    = bus.RegWrite_o;
    o.rdst  = bus.RegDst_o;
    o.m2r   = bus.MemtoReg_o;
    o.done  = bus.instr_done_o;
    o.ill   = bus.illegal_o;
    return o;
  endfunction

  function automatic cyc_t blank(input logic [3:0] st, input logic [5:0] op, input int iid);
    cyc_t c;
    c.st    = st;
    c.op    = op;
    c.ready = 1'($urandom);
    c.ctl   = '{alu: 3'b100, default: '0};
    c.iid   = iid;
    return c;
  endfunction

  // Expand one instruction into its expected cycle trace.
  task automatic push_instr(input int kind, input logic [5:0] op_in, input int fs, input int ms);
    cyc_t c;
    logic [5:0] op;
    int id;
    id = instr_no + q.size() + 1000 * 0;
    case (kind)
      KR:      op = 6'b000000;
      KLW:     op = 6'b100011;
      KSW:     op = 6'b101011;
      KBEQ:    op = 6'b000100;
      KADDI:   op = 6'b001000;
      KJ:      op = 6'b000010;
      default: op = op_in;
    endcase
    for (int i = 0; i <= fs; i++) begin
      c = blank(4'd1, 6'($urandom), id);
      c.ctl.mr = 1'b1; c.ctl.src_b = 2'b01;
      c.ready = (i == fs);
      c.ctl.irw = c.ready; c.ctl.pcw = c.ready;
      q.push_back(c);
    end
    c = blank(4'd2, op, id);
    c.ctl.src_b = 2'b11;
    c.ctl.ill = (kind == KILL);
    q.push_back(c);
    case (kind)
      KR: begin
        c = blank(4'd7, op, id); c.ctl.src_a = 1'b1; c.ctl.alu = 3'b010; q.push_back(c);
        c = blank(4'd8, op, id); c.ctl.rw = 1'b1; c.ctl.rdst = 1'b1; c.ctl.done = 1'b1;
        q.push_back(c);
      end
      KLW, KSW: begin
        c = blank(4'd3, op, id); c.ctl.src_a = 1'b1; c.ctl.src_b = 2'b10; q.push_back(c);
        for (int i = 0; i <= ms; i++) begin
          c = blank((kind == KLW) ? 4'd4 : 4'd6, op, id);
          c.ready = (i == ms);
          c.ctl.iord = 1'b1;
          if (kind == KLW) c.ctl.mr = 1'b1;
          else begin c.ctl.mw = 1'b1; c.ctl.done = c.ready; end
          q.push_back(c);
        end
        if (kind == KLW) begin
          c = blank(4'd5, op, id); c.ctl.rw = 1'b1; c.ctl.m2r = 1'b1; c.ctl.done = 1'b1;
          q.push_back(c);
        end
      end
      KBEQ: begin
        c = blank(4'd9, op, id);
        c.ctl.src_a = 1'b1; c.ctl.alu = 3'b101; c.ctl.pcwc = 1'b1; c.ctl.pcsrc = 2'b01;
        c.ctl.done = 1'b1;
        q.push_back(c);
      end
      KADDI: begin
        c = blank(4'd10, op, id); c.ctl.src_a = 1'b1; c.ctl.src_b = 2'b10; q.push_back(c);
        c = blank(4'd11, op, id); c.ctl.rw = 1'b1; c.ctl.done = 1'b1; q.push_back(c);
      end
      KJ: begin
        c = blank(4'd12, op, id); c.ctl.pcw = 1'b1; c.ctl.pcsrc = 2'b10; c.ctl.done = 1'b1;
        q.push_back(c);
      end
      default: ;
    endcase
    if (kind != KILL) retired_exp++;
  endtask

  task automatic run_cycle(input cyc_t c);
    @(negedge clk);
    bus.instr_op_i  = c.op;
    bus.mem_ready_i = c.ready;
    instr_no = c.iid;
    #1;
    cyc_no++;
    check("state", 32'(bus.state_o), 32'(c.st));
    check("ctrl", 32'(obs_ctl()), 32'(c.ctl));
    if (bus.instr_done_o) done_seen++;
  endtask

  task automatic run_all();
    while (q.size() > 0) run_cycle(q.pop_front());
  endtask

  function automatic logic [5:0] rand_illegal();
    logic [5:0] op;
    do op = 6'($urandom);
    while (op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010});
    return op;
  endfunction

  initial begin
    cyc_t c;
    int   k;
    idle_ctl = '{alu: 3'b100, default: '0};
    bus.instr_op_i  = 6'b111111;
    bus.mem_ready_i = 1'b1;

    // Reset held: everything idle even with ready high and an illegal opcode present.
    repeat (3) @(negedge clk);
    #1;
    check("rst_state", 32'(bus.state_o), 32'd0);
    check("rst_ctrl", 32'(obs_ctl()), 32'(idle_ctl));
    rst_n = 1'b1;
    #1;
    check("rel_state", 32'(bus.state_o), 32'd0);

    // Directed: R, lw with 2-cycle MEMRD stall, beq then j, fetch stall, illegal, sw stall.
    push_instr(KR, 6'd0, 0, 0);
    push_instr(KLW, 6'd0, 0, 2);
    push_instr(KBEQ, 6'd0, 0, 0);
    push_instr(KJ, 6'd0, 0, 0);
    push_instr(KADDI, 6'd0, 3, 0);
    push_instr(KILL, 6'b111111, 0, 0);
    push_instr(KSW, 6'd0, 1, 1);
    run_all();

    // Random instruction stream.
    for (int i = 0; i < 250; i++) begin
      k = int'($urandom_range(0, 6));
      push_instr(k, rand_illegal(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      run_all();
    end
    check("retired", 32'(done_seen), 32'(retired_exp));

    // Asynchronous reset while a store is waiting on memory.
    push_instr(KSW, 6'd0, 0, 3);
    while (q.size() > 0) begin
      c = q.pop_front();
      run_cycle(c);
      if (c.st == 4'd6) break;
    end
    q.delete();
    check("memwr_mw", 32'(bus.MemWrite_o), 32'd1);
    #2;
    rst_n = 1'b0;
    bus.mem_ready_i = 1'b1;
    #1;
    check("mid_rst_mw", 32'(bus.MemWrite_o), 32'd0);
    check("mid_rst_state", 32'(bus.state_o), 32'd0);
    check("mid_rst_ctrl", 32'(obs_ctl()), 32'(idle_ctl));
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    push_instr(KR, 6'd0, 0, 0);
    run_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
